// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// DMA starvation guard: counts cycles a pending DMA request has been refused
// and raises force_grant once MAX_WAIT refusals have accumulated.
module dmem_arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    input  logic gnt,
    output logic force_grant
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;

    // Count refused cycles, saturating at MAX_WAIT; clear on grant or withdrawal
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (gnt || !pending) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_grant = (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority with 0-cycle access,
// DMA uses valid/ready with a bounded-wait starvation guard.
// Optional stats counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DMEM_DEPTH_WORDS = 1024,
    parameter int unsigned MAX_WAIT         = 4,
    localparam int unsigned AW              = $clog2(DMEM_DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_valid,
    input  logic                  dma_we,
    input  logic [AW-1:0]         dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ready,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_cpu_stall_cnt,
    output logic [STAT_W-1:0]     stat_dma_xfer_cnt
`endif
);

    logic   cpu_req;
    logic   force_grant;
    logic   dma_gnt;
    owner_e owner_q;
    owner_e owner_d;

    assign cpu_req   = cpu_re | cpu_we;
    assign dma_gnt   = dma_valid & (~cpu_req | force_grant);
    assign dma_ready = dma_gnt;
    assign cpu_stall = cpu_req & dma_gnt;
    assign cpu_rdata = mem_rdata;

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .pending     (dma_valid),
        .gnt         (dma_gnt),
        .force_grant (force_grant)
    );

    // Owner state register: records who owned the memory last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Next owner is the owner of the current cycle
    always_comb begin
        owner_d = OWN_IDLE;
        if (dma_gnt) begin
            owner_d = OWN_DMA;
        end else if (cpu_req) begin
            owner_d = OWN_CPU;
        end
    end

    // Memory port mux driven by the current-cycle owner
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (owner_d)
            OWN_DMA: begin
                mem_addr     = dma_addr;
                mem_wdata    = dma_wdata;
                mem_read_en  = ~dma_we;
                mem_write_en = dma_we;
            end
            OWN_CPU: begin
                mem_addr     = cpu_addr;
                mem_wdata    = cpu_wdata;
                mem_read_en  = cpu_re;
                mem_write_en = cpu_we;
            end
            default: begin
            end
        endcase
    end

    // DMA read response: capture data one cycle after a granted read
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else if (dma_gnt && !dma_we) begin
            dma_rvalid <= 1'b1;
            dma_rdata  <= mem_rdata;
        end else begin
            dma_rvalid <= 1'b0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating event counters for stall and DMA transfer cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cpu_stall_cnt <= '0;
            stat_dma_xfer_cnt  <= '0;
        end else begin
            if (cpu_stall && (stat_cpu_stall_cnt != '1)) begin
                stat_cpu_stall_cnt <= stat_cpu_stall_cnt + 1'b1;
            end
            if (dma_gnt && (stat_dma_xfer_cnt != '1)) begin
                stat_dma_xfer_cnt <= stat_dma_xfer_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
// Stats checks are included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_re, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_valid, dma_we, dma_ready, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read_en, mem_write_en;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_cpu_stall_cnt, stat_dma_xfer_cnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [DW-1:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_WIDTH       (32),
        .DMEM_DEPTH_WORDS (1024),
        .MAX_WAIT         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_re       (cpu_re),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dma_valid    (dma_valid),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_ready    (dma_ready),
        .dma_rvalid   (dma_rvalid),
        .dma_rdata    (dma_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_stall_cnt (stat_cpu_stall_cnt),
        .stat_dma_xfer_cnt  (stat_dma_xfer_cnt)
`endif
    );

    // Behavioural single-port memory: combinational read, write at the edge
    always_ff @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
        end
        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_valid = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;

        // Reset state
        tick();
        tick();
        mid();
        check("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
        check("rst_rdata", dma_rdata, 32'd0);
        check("idle_rd_en", {31'b0, mem_read_en}, 32'd0);
        check("idle_wr_en", {31'b0, mem_write_en}, 32'd0);
        check("idle_addr", {22'b0, mem_addr}, 32'd0);
        tick();
        rst = 1'b0;

        // DMA write then read of addr 5
        dma_valid = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 10'd5;
        dma_wdata = 32'hDEADBEEF;
        mid();
        check("dw_ready", {31'b0, dma_ready}, 32'd1);
        check("dw_wr_en", {31'b0, mem_write_en}, 32'd1);
        check("dw_addr", {22'b0, mem_addr}, 32'd5);
        check("dw_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        dma_we = 1'b0;
        mid();
        check("dr_ready", {31'b0, dma_ready}, 32'd1);
        check("dr_rd_en", {31'b0, mem_read_en}, 32'd1);
        check("dr_rvalid_early", {31'b0, dma_rvalid}, 32'd0);
        tick();
        dma_valid = 1'b0;
        mid();
        check("dr_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("dr_rdata", dma_rdata, 32'hDEADBEEF);
        tick();
        mid();
        check("dr_rvalid_drop", {31'b0, dma_rvalid}, 32'd0);
        check("dr_rdata_hold", dma_rdata, 32'hDEADBEEF);
        tick();

        // CPU store then load of addr 9
        cpu_we    = 1'b1;
        cpu_addr  = 10'd9;
        cpu_wdata = 32'h12345678;
        mid();
        check("cw_stall", {31'b0, cpu_stall}, 32'd0);
        check("cw_wr_en", {31'b0, mem_write_en}, 32'd1);
        check("cw_addr", {22'b0, mem_addr}, 32'd9);
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b1;
        mid();
        check("cr_rdata", cpu_rdata, 32'h12345678);
        check("cr_stall", {31'b0, cpu_stall}, 32'd0);
        check("cr_rd_en", {31'b0, mem_read_en}, 32'd1);
        tick();

        // Continuous CPU loads, DMA read held valid: grant on 5th cycle
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 10'd5;
        for (int i = 1; i <= 5; i++) begin
            mid();
            check($sformatf("ct_ready_%0d", i), {31'b0, dma_ready}, (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("ct_stall_%0d", i), {31'b0, cpu_stall}, (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("ct_addr_%0d", i), {22'b0, mem_addr}, (i == 5) ? 32'd5 : 32'd9);
            tick();
        end
        dma_valid = 1'b0;
        mid();
        check("ct_after_stall", {31'b0, cpu_stall}, 32'd0);
        check("ct_after_rdata", cpu_rdata, 32'h12345678);
        check("ct_after_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("ct_after_dmadata", dma_rdata, 32'hDEADBEEF);
        tick();

        // DMA valid dropped after 2 refusals restarts the wait count
        dma_valid = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            mid();
            check($sformatf("dv_pre_ready_%0d", i), {31'b0, dma_ready}, 32'd0);
            tick();
        end
        dma_valid = 1'b0;
        mid();
        check("dv_gap_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        dma_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            mid();
            check($sformatf("dv_ready_%0d", i), {31'b0, dma_ready}, (i == 5) ? 32'd1 : 32'd0);
            tick();
        end
        dma_valid = 1'b0;
        cpu_re    = 1'b0;
        mid();
        tick();

        // Reset the cycle after a granted DMA read; a write granted under reset still lands
        dma_valid = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 10'd9;
        mid();
        check("rr_ready", {31'b0, dma_ready}, 32'd1);
        tick();
        rst       = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 10'd20;
        dma_wdata = 32'hA5A5A5A5;
        mid();
        check("rr_pending_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check("rr_pending_rdata", dma_rdata, 32'h12345678);
        check("rr_wr_ready", {31'b0, dma_ready}, 32'd1);
        tick();
        rst       = 1'b0;
        dma_valid = 1'b0;
        dma_we    = 1'b0;
        cpu_re    = 1'b1;
        cpu_addr  = 10'd20;
        mid();
        check("rr_rvalid", {31'b0, dma_rvalid}, 32'd0);
        check("rr_rdata", dma_rdata, 32'd0);
        check("rr_wr_landed", cpu_rdata, 32'hA5A5A5A5);
`ifdef DMEM_ARB_STATS_EN
        check("rr_stat_stall", stat_cpu_stall_cnt, 32'd0);
        check("rr_stat_xfer", stat_dma_xfer_cnt, 32'd0);
`endif
        tick();

        // Ten cycles of contention: grants on cycles 5 and 10
        cpu_addr  = 10'd9;
        dma_valid = 1'b1;
        dma_addr  = 10'd5;
        for (int i = 1; i <= 10; i++) begin
            mid();
            check($sformatf("st_ready_%0d", i), {31'b0, dma_ready},
                  (i == 5 || i == 10) ? 32'd1 : 32'd0);
            tick();
        end
        cpu_re    = 1'b0;
        dma_valid = 1'b0;
        mid();
`ifdef DMEM_ARB_STATS_EN
        check("st_stall_cnt", stat_cpu_stall_cnt, 32'd2);
        check("st_xfer_cnt", stat_dma_xfer_cnt, 32'd2);
`endif
        check("st_rdata", dma_rdata, 32'hDEADBEEF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
